// File: rtl/rrf_free_list.sv
// Retirement register file plus physical-register free list, fed by the ROB commit stream.
// Define RRF_STATS_EN to add saturating commit and allocation-stall counters.
module rrf_free_list #(
    parameter  int NUM_PHYS = 64,
    parameter  int NUM_ARCH = 32,
    localparam int PW       = $clog2(NUM_PHYS),
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int CW       = $clog2(FL_DEPTH) + 1,
    localparam int SW       = CW - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_valid,
    input  logic [PW-1:0]          commit_pd,
    input  logic [4:0]             commit_rd,
    input  logic                   commit_we,
    input  logic                   alloc_req,
    output logic [PW-1:0]          free_pd,
    output logic                   fl_empty,
    input  logic                   flush,
    output logic [NUM_ARCH*PW-1:0] rrf_map,
    output logic [CW-1:0]          fl_count
`ifdef RRF_STATS_EN
    ,
    output logic [31:0]            stat_commits,
    output logic [31:0]            stat_stalls
`endif
);

    localparam logic [CW-1:0] PTR_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] PTR_ZERO = {CW{1'b0}};

    logic [PW-1:0] mem_q [FL_DEPTH];
    logic [PW-1:0] mem_d [FL_DEPTH];
    logic [PW-1:0] map_q [NUM_ARCH];
    logic [PW-1:0] map_d [NUM_ARCH];
    logic [CW-1:0] head_q, head_d;
    logic [CW-1:0] tail_q, tail_d;
    logic [CW-1:0] ret_q, ret_d;
    logic          push_s;
    logic          pop_s;

    // Pointer-derived status and the zero-latency head read.
    always_comb begin
        fl_empty = (head_q == tail_q);
        fl_count = tail_q - head_q;
        free_pd  = mem_q[head_q[SW-1:0]];
        for (int i = 0; i < NUM_ARCH; i++) begin
            rrf_map[i*PW +: PW] = map_q[i];
        end
    end

    // Commit returns the displaced mapping to the tail; flush rewinds head to the retire point.
    always_comb begin
        push_s = commit_valid && commit_we && (commit_rd != 5'd0);
        pop_s  = alloc_req && !fl_empty && !flush;
        mem_d  = mem_q;
        map_d  = map_q;
        tail_d = tail_q;
        ret_d  = ret_q;
        head_d = head_q;
        if (push_s) begin
            mem_d[tail_q[SW-1:0]] = map_q[commit_rd];
            map_d[commit_rd]      = commit_pd;
            tail_d                = tail_q + PTR_ONE;
            ret_d                 = ret_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
            ret_d  = ret_q;
        end
        // The rewind target already includes this cycle's retirement.
        if (flush) begin
            head_d = ret_d;
        end else if (pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
    end

    // State registers; reset restores the identity map and a full free list of the upper phys regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PW'(NUM_ARCH + i);
            end
            for (int i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= PW'(i);
            end
            head_q <= PTR_ZERO;
            ret_q  <= PTR_ZERO;
            tail_q <= CW'(FL_DEPTH);
        end else begin
            mem_q  <= mem_d;
            map_q  <= map_d;
            head_q <= head_d;
            ret_q  <= ret_d;
            tail_q <= tail_d;
        end
    end

`ifdef RRF_STATS_EN
    logic [31:0] commits_q, commits_d;
    logic [31:0] stalls_q, stalls_d;

    // Saturating event counters, untouched by flush.
    always_comb begin
        commits_d = commits_q;
        stalls_d  = stalls_q;
        if (commit_valid && (commits_q != 32'hFFFF_FFFF)) begin
            commits_d = commits_q + 32'd1;
        end else begin
            commits_d = commits_q;
        end
        if (alloc_req && fl_empty && (stalls_q != 32'hFFFF_FFFF)) begin
            stalls_d = stalls_q + 32'd1;
        end else begin
            stalls_d = stalls_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            commits_q <= 32'd0;
            stalls_q  <= 32'd0;
        end else begin
            commits_q <= commits_d;
            stalls_q  <= stalls_d;
        end
    end

    assign stat_commits = commits_q;
    assign stat_stalls  = stalls_q;
`endif

endmodule
